// File: rtl/npu_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_sram_pkg
// Description : Shared constants and types for the NPU SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_sram_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_ADDR_W  = 14;
    localparam int C_DATA_W  = 16;
    localparam int C_BE_W    = C_DATA_W / 8;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [$clog2(C_NUM_REQ)-1:0] req_idx_t;

    // Round-robin successor of idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : npu_sram_pkg
`default_nettype wire

// File: rtl/npu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : npu_rr_pick
// Description : Combinational round-robin picker; first set request at or
//               after the start pointer, modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule : npu_rr_pick
`default_nettype wire

// File: rtl/npu_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : npu_sram_port_arbiter
// Description : Round-robin arbiter with locked bursts sharing one SRAM port
//               among NUM_REQ requesters. NPU_SRAM_ARB_HIPRI_EN gives
//               requester 0 strict priority outside locked bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_sram_port_arbiter
    import npu_sram_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int ADDR_W  = C_ADDR_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int BE_W    = C_BE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   req_be,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         sram_address,
    output logic [BE_W-1:0]           sram_byteenable,
    output logic                      sram_chipselect,
    output logic                      sram_write,
    output logic [DATA_W-1:0]         sram_writedata,
    input  logic [DATA_W-1:0]         sram_readdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t        state_q;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  w_rr_nxt;
    logic [IDX_W-1:0]  own_q;
    logic [IDX_W-1:0]  w_own_nxt;
    logic              rd_pend_q;
    logic [IDX_W-1:0]  rd_id_q;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic               w_adv_rr;

    logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];
    logic [BE_W-1:0]   w_be_arr    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign w_be_arr[gi]    = req_be[gi*BE_W +: BE_W];
    end

    npu_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (rr_q),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    // Winner selection; a held lock excludes everyone but the owner.
    always_comb begin
        w_win_idx   = w_pick_idx;
        w_win_valid = w_pick_any;
        if (state_q == LOCKED) begin
            w_win_idx   = own_q;
            w_win_valid = req_valid[own_q];
        end
`ifdef NPU_SRAM_ARB_HIPRI_EN
        else if (req_valid[0]) begin
            w_win_idx   = '0;
            w_win_valid = 1'b1;
        end
`endif
        if (reset) begin
            w_win_valid = 1'b0;
        end
    end

    always_comb begin
        req_ready       = '0;
        sram_address    = '0;
        sram_byteenable = '0;
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        sram_writedata  = '0;
        if (w_win_valid) begin
            req_ready[w_win_idx] = 1'b1;
            sram_address         = w_addr_arr[w_win_idx];
            sram_byteenable      = w_be_arr[w_win_idx];
            sram_chipselect      = 1'b1;
            sram_write           = req_write[w_win_idx];
            sram_writedata       = w_wdata_arr[w_win_idx];
        end
    end

`ifdef NPU_SRAM_ARB_HIPRI_EN
    // Priority grants to requester 0 leave the rotation among the others intact.
    assign w_adv_rr = (w_win_idx != '0);
`else
    assign w_adv_rr = 1'b1;
`endif

    always_comb begin
        w_state_nxt = state_q;
        w_rr_nxt    = rr_q;
        w_own_nxt   = own_q;
        if (w_win_valid) begin
            if (req_lock[w_win_idx]) begin
                w_state_nxt = LOCKED;
                w_own_nxt   = w_win_idx;
            end else begin
                w_state_nxt = ARB;
                if (w_adv_rr) begin
                    w_rr_nxt = IDX_W'(rr_next(32'(w_win_idx), NUM_REQ));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            rr_q      <= '0;
            own_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            state_q   <= w_state_nxt;
            rr_q      <= w_rr_nxt;
            own_q     <= w_own_nxt;
            rd_pend_q <= w_win_valid & ~req_write[w_win_idx];
            rd_id_q   <= w_win_idx;
        end
    end

    // SRAM read data is unregistered and lands one cycle after the address.
    always_comb begin
        rsp_valid = '0;
        if (rd_pend_q && !reset) begin
            rsp_valid[rd_id_q] = 1'b1;
        end
    end

    assign rsp_rdata = sram_readdata;

endmodule : npu_sram_port_arbiter
`default_nettype wire

// File: tb/tb_npu_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_sram_port_arbiter
// Description : Directed self-checking bench for npu_sram_port_arbiter with a
//               behavioural SRAM whose contents reset to addr ^ 16'hA5C3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_write;
    logic [3:0]  req_lock;
    logic [55:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic [13:0] sram_address;
    logic [1:0]  sram_byteenable;
    logic        sram_chipselect;
    logic        sram_write;
    logic [15:0] sram_writedata;
    logic [15:0] sram_readdata;

    logic [15:0] mem [0:16383];
    logic [15:0] rd_q;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    npu_sram_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_lock        (req_lock),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_be          (req_be),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .sram_address    (sram_address),
        .sram_byteenable (sram_byteenable),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .sram_readdata   (sram_readdata)
    );

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16384; k++) mem[k] <= 16'(k) ^ 16'hA5C3;
        end else if (sram_chipselect) begin
            if (sram_write) begin
                if (sram_byteenable[0]) mem[sram_address][7:0]  <= sram_writedata[7:0];
                if (sram_byteenable[1]) mem[sram_address][15:8] <= sram_writedata[15:8];
            end else begin
                rd_q <= mem[sram_address];
            end
        end
    end
    assign sram_readdata = rd_q;

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_lock[i]          = l;
        req_addr[i*14 +: 14] = a;
        req_wdata[i*16 +: 16] = d;
        req_be[i*2 +: 2]     = be;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 14'h100 + 14'(i), 16'h0, 2'b11);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        n_cmp++; if (sram_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs got %b exp 0", sram_chipselect); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp got %b exp 0000", rsp_valid); end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [4];
        logic [3:0]  e;
        logic [3:0]  ep;
        exp_d = '{16'hA4C3, 16'hA4C2, 16'hA4C1, 16'hA4C0};
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 14'h100 + 14'(i), 16'h0, 2'b11);
            e  = 4'(1 << (k % 4));
            ep = 4'(1 << ((k + 3) % 4));
            @(negedge clk);
            n_cmp++; if (req_ready !== e) begin n_fail++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, e); end
            n_cmp++; if (sram_address !== 14'h100 + 14'(k % 4)) begin n_fail++; $display("FAIL rr_addr k=%0d got %h exp %h", k, sram_address, 14'h100 + 14'(k % 4)); end
            n_cmp++; if (sram_chipselect !== 1'b1 || sram_write !== 1'b0) begin n_fail++; $display("FAIL rr_cs_wr k=%0d got %b%b exp 10", k, sram_chipselect, sram_write); end
            if (k > 0) begin
                n_cmp++; if (rsp_valid !== ep) begin n_fail++; $display("FAIL rr_rsp k=%0d got %b exp %b", k, rsp_valid, ep); end
                n_cmp++; if (rsp_rdata !== exp_d[(k + 3) % 4]) begin n_fail++; $display("FAIL rr_rdata k=%0d got %h exp %h", k, rsp_rdata, exp_d[(k + 3) % 4]); end
            end
            next_cycle();
        end
        clear_all();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL rr_last_rsp got %b exp 1000", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 16'hA4C0) begin n_fail++; $display("FAIL rr_last_rdata got %h exp a4c0", rsp_rdata); end
        n_cmp++; if (sram_chipselect !== 1'b0 || sram_write !== 1'b0 || sram_address !== 14'h0) begin
            n_fail++; $display("FAIL idle_outputs got cs=%b wr=%b addr=%h exp 0 0 0", sram_chipselect, sram_write, sram_address); end
        next_cycle();
    endtask

    task automatic test_byteenable_write();
        set_req(2, 1'b1, 1'b1, 1'b0, 14'h1234, 16'hBEEF, 2'b10);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wr_ready got %b exp 0100", req_ready); end
        n_cmp++; if (sram_write !== 1'b1 || sram_writedata !== 16'hBEEF || sram_byteenable !== 2'b10 || sram_address !== 14'h1234) begin
            n_fail++; $display("FAIL wr_port got wr=%b d=%h be=%b a=%h exp 1 beef 10 1234", sram_write, sram_writedata, sram_byteenable, sram_address); end
        next_cycle();
        set_req(2, 1'b1, 1'b0, 1'b0, 14'h1234, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100 || sram_write !== 1'b0) begin n_fail++; $display("FAIL rd_ready got %b wr=%b exp 0100 0", req_ready, sram_write); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_no_rsp got %b exp 0000", rsp_valid); end
        next_cycle();
        clear_all();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL rdback_rsp got %b exp 0100", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 16'hBEF7) begin n_fail++; $display("FAIL rdback_data got %h exp bef7", rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_locked_burst();
        logic [15:0] exp_d [4];
        exp_d = '{16'hA5D3, 16'hA5D2, 16'hA5D1, 16'hA5D0};
        // rr_q is 3 here; a lone beat by 0 moves it to 1.
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h40, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lk_setup got %b exp 0001", req_ready); end
        next_cycle();
        set_req(3, 1'b1, 1'b0, 1'b0, 14'h33, 16'h0, 2'b11);
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b0, (k < 3), 14'h10 + 14'(k), 16'h0, 2'b11);
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'b0010 || sram_address !== 14'h10 + 14'(k)) begin
                n_fail++; $display("FAIL lk_grant k=%0d got %b a=%h exp 0010 a=%h", k, req_ready, sram_address, 14'h10 + 14'(k)); end
            if (k == 0) begin
                n_cmp++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 16'hA583) begin n_fail++; $display("FAIL lk_rsp0 got %b %h exp 0001 a583", rsp_valid, rsp_rdata); end
            end else begin
                n_cmp++; if (rsp_valid !== 4'b0010 || rsp_rdata !== exp_d[k-1]) begin n_fail++; $display("FAIL lk_rsp k=%0d got %b %h exp 0010 %h", k, rsp_valid, rsp_rdata, exp_d[k-1]); end
            end
            next_cycle();
        end
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000 || sram_address !== 14'h33) begin n_fail++; $display("FAIL lk_after got %b a=%h exp 1000 a=0033", req_ready, sram_address); end
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA5D0) begin n_fail++; $display("FAIL lk_last_rsp got %b %h exp 0010 a5d0", rsp_valid, rsp_rdata); end
        next_cycle();
        clear_all();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 16'hA5F0) begin n_fail++; $display("FAIL lk_r3_rsp got %b %h exp 1000 a5f0", rsp_valid, rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_lock_stall();
        set_req(1, 1'b1, 1'b0, 1'b1, 14'h20, 16'h0, 2'b11);
        set_req(2, 1'b1, 1'b0, 1'b0, 14'h22, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL st_lock got %b exp 0010", req_ready); end
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 2'b11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'b0000 || sram_chipselect !== 1'b0) begin
                n_fail++; $display("FAIL st_stall k=%0d got %b cs=%b exp 0000 0", k, req_ready, sram_chipselect); end
            if (k == 0) begin
                n_cmp++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA5E3) begin n_fail++; $display("FAIL st_rsp got %b %h exp 0010 a5e3", rsp_valid, rsp_rdata); end
            end
            next_cycle();
        end
        set_req(1, 1'b1, 1'b0, 1'b0, 14'h21, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010 || sram_chipselect !== 1'b1) begin n_fail++; $display("FAIL st_resume got %b cs=%b exp 0010 1", req_ready, sram_chipselect); end
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL st_release got %b exp 0100", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA5E2) begin n_fail++; $display("FAIL st_rsp2 got %b %h exp 0010 a5e2", rsp_valid, rsp_rdata); end
        next_cycle();
        clear_all();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 16'hA5E1) begin n_fail++; $display("FAIL st_rsp3 got %b %h exp 0100 a5e1", rsp_valid, rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        set_req(3, 1'b1, 1'b0, 1'b1, 14'h30, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rb_grant got %b exp 1000", req_ready); end
        next_cycle();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h40, 16'h0, 2'b11);
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rb_rsp_supp got %b exp 0000", rsp_valid); end
        n_cmp++; if (req_ready !== 4'b0000 || sram_chipselect !== 1'b0) begin n_fail++; $display("FAIL rb_in_reset got %b cs=%b exp 0000 0", req_ready, sram_chipselect); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001 || sram_address !== 14'h40) begin n_fail++; $display("FAIL rb_first got %b a=%h exp 0001 a=0040", req_ready, sram_address); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rb_no_rsp got %b exp 0000", rsp_valid); end
        next_cycle();
        clear_all();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 16'hA583) begin n_fail++; $display("FAIL rb_rsp got %b %h exp 0001 a583", rsp_valid, rsp_rdata); end
        next_cycle();
    endtask

`ifdef NPU_SRAM_ARB_HIPRI_EN
    task automatic test_hipri();
        logic [3:0] e_rot [4];
        e_rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_req(i, (k < 4) || (i != 0), 1'b0, 1'b0, 14'h100 + 14'(i), 16'h0, 2'b11);
            @(negedge clk);
            if (k < 4) begin
                n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL hp_prio k=%0d got %b exp 0001", k, req_ready); end
            end else begin
                n_cmp++; if (req_ready !== e_rot[k-4]) begin n_fail++; $display("FAIL hp_rot k=%0d got %b exp %b", k, req_ready, e_rot[k-4]); end
            end
            next_cycle();
        end
        clear_all();
        next_cycle();
    endtask
`endif

    initial begin
        reset = 1'b1;
        rd_q  = 16'h0;
        clear_all();
        test_reset();
`ifdef NPU_SRAM_ARB_HIPRI_EN
        test_hipri();
`else
        test_round_robin();
        test_byteenable_write();
        test_locked_burst();
        test_lock_stall();
        test_reset_mid_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_npu_sram_port_arbiter
`default_nettype wire
